// File: rtl/cpu_core.sv
// cpu_core: 32-bit load/store CPU executing out of an external word RAM over a 4-phase txe/txs bus.
// Latency: every instruction takes one fetch handshake plus one EX cycle; LW/SW add a second handshake.
// Backpressure: the RAM paces the core through txs; at most one transaction is outstanding at any time.
//
// Ports:
//   clk, rst_n        CPU clock (rising edge) and asynchronous active-low reset
//   ram_txe           request to the RAM, held high until the synchronized acknowledge is seen
//   ram_txs           acknowledge from the RAM, asynchronous to clk (synchronized internally)
//   ram_re / ram_we   read / write qualifier, never both high
//   ram_addr, ram_wd  word-aligned byte address and write data, stable while ram_txe=1
//   ram_out           read data, sampled when the synchronized acknowledge arrives
//   hlt               sticky halted flag, set on HLT or an undefined opcode
module cpu_core #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ram_txe,
  input  logic        ram_txs,
  output logic        ram_re,
  input  logic [31:0] ram_out,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  output logic [63:0] ram_addr,
  output logic        hlt
);

  typedef enum logic [2:0] {
    IF_REQ,
    IF_ACK,
    IF_REL,
    EX,
    MEM_REQ,
    MEM_ACK,
    MEM_REL,
    HALT
  } state_t;

  localparam logic [3:0] OP_HLT  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_SLT  = 4'hD;

  state_t      state;
  state_t      state_nxt;

  logic [63:0] pc;
  logic [31:0] rf [16];
  logic [31:0] ir;
  logic        fetched;   // ir holds a real instruction (cleared only by reset)
  logic [1:0]  boot_cnt;  // settle time for the synchronizer after reset
  logic        txs_meta;
  logic        txs_sync;

  // ---------------------------------------------------------------- decode
  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [31:0] imm16_sx;
  logic [31:0] imm20_sx;
  logic [31:0] rd_val;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign op       = ir[31:28];
  assign rd       = ir[27:24];
  assign rs       = ir[23:20];
  assign rt       = ir[19:16];
  assign imm16_sx = {{16{ir[15]}}, ir[15:0]};
  assign imm20_sx = {{12{ir[19]}}, ir[19:0]};

  assign rd_val = (rd == 4'd0) ? 32'd0 : rf[rd];
  assign rs_val = (rs == 4'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 4'd0) ? 32'd0 : rf[rt];

  logic is_halt;
  logic is_mem;
  logic alu_wen;

  // 0, E and F all stop the core
  assign is_halt = (op == OP_HLT) || (op == 4'hE) || (op == 4'hF);
  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign alu_wen = (op == OP_LI)  || (op == OP_ADD) || (op == OP_SUB) ||
                   (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR) ||
                   (op == OP_ADDI)|| (op == OP_JAL) || (op == OP_SLT);

  // ---------------------------------------------------------------- execute
  logic [31:0] alu_res;
  logic [31:0] ea32;
  logic [31:0] jal_tgt;
  logic [63:0] pc_inc;
  logic [63:0] br_tgt;

  assign ea32    = rs_val + imm16_sx;
  assign jal_tgt = rs_val + {imm16_sx[29:0], 2'b00};
  assign pc_inc  = pc + 64'd4;
  assign br_tgt  = pc_inc + {{46{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    alu_res = 32'd0;
    case (op)
      OP_LI:   alu_res = imm20_sx;
      OP_ADD:  alu_res = rs_val + rt_val;
      OP_SUB:  alu_res = rs_val - rt_val;
      OP_AND:  alu_res = rs_val & rt_val;
      OP_OR:   alu_res = rs_val | rt_val;
      OP_XOR:  alu_res = rs_val ^ rt_val;
      OP_ADDI: alu_res = rs_val + imm16_sx;
      OP_JAL:  alu_res = pc[31:0] + 32'd4;
      OP_SLT:  alu_res = {31'd0, ($signed(rs_val) < $signed(rt_val))};
      default: alu_res = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------- txs synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txs_meta <= 1'b0;
      txs_sync <= 1'b0;
    end else begin
      txs_meta <= ram_txs;
      txs_sync <= txs_meta;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IF_REL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IF_REQ:  if (!txs_sync) state_nxt = IF_ACK;
      IF_ACK:  if (txs_sync)  state_nxt = IF_REL;
      // Out of reset the synchronizer reads 0 regardless of the RAM, so the
      // first fetch also waits for boot_cnt before trusting txs_sync.
      IF_REL: begin
        if (!txs_sync) begin
          if (fetched)                state_nxt = EX;
          else if (boot_cnt == 2'd3)  state_nxt = IF_REQ;
        end
      end
      EX: begin
        if (is_halt)     state_nxt = HALT;
        else if (is_mem) state_nxt = MEM_REQ;
        else             state_nxt = IF_REQ;
      end
      MEM_REQ: if (!txs_sync) state_nxt = MEM_ACK;
      MEM_ACK: if (txs_sync)  state_nxt = MEM_REL;
      MEM_REL: if (!txs_sync) state_nxt = IF_REQ;
      HALT:    state_nxt = HALT;
      default: state_nxt = IF_REL;
    endcase
  end

  // ---------------------------------------------------------------- pc, ir, bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= 32'd0;
      fetched  <= 1'b0;
      boot_cnt <= 2'd0;
      hlt      <= 1'b0;
      ram_txe  <= 1'b0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      ram_wd   <= 32'd0;
      ram_addr <= 64'd0;
    end else begin
      case (state)
        IF_REL: begin
          if (!fetched && boot_cnt != 2'd3) boot_cnt <= boot_cnt + 2'd1;
        end
        IF_REQ: begin
          if (!txs_sync) begin
            ram_addr <= {pc[63:2], 2'b00};
            ram_re   <= 1'b1;
            ram_we   <= 1'b0;
            ram_txe  <= 1'b1;
          end
        end
        IF_ACK: begin
          if (txs_sync) begin
            ir      <= ram_out;
            fetched <= 1'b1;
            ram_txe <= 1'b0;
            ram_re  <= 1'b0;
            ram_we  <= 1'b0;
          end
        end
        EX: begin
          if (is_halt) begin
            hlt <= 1'b1;  // pc keeps the halting instruction's address
          end else begin
            case (op)
              OP_BEQ:  pc <= (rd_val == rs_val) ? br_tgt : pc_inc;
              OP_BNE:  pc <= (rd_val != rs_val) ? br_tgt : pc_inc;
              OP_JAL:  pc <= {32'd0, jal_tgt};
              default: pc <= pc_inc;
            endcase
          end
        end
        MEM_REQ: begin
          if (!txs_sync) begin
            // effective address wraps at 32 bits, then zero-extends
            ram_addr <= {32'd0, ea32 & 32'hFFFF_FFFC};
            ram_re   <= (op == OP_LW);
            ram_we   <= (op == OP_SW);
            if (op == OP_SW) ram_wd <= rd_val;
            ram_txe  <= 1'b1;
          end
        end
        MEM_ACK: begin
          if (txs_sync) begin
            ram_txe <= 1'b0;
            ram_re  <= 1'b0;
            ram_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- register file
  logic        rf_wen;
  logic [31:0] rf_wdat;

  assign rf_wen  = ((state == EX) && alu_wen) ||
                   ((state == MEM_ACK) && txs_sync && (op == OP_LW));
  assign rf_wdat = (state == MEM_ACK) ? ram_out : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
    end else if (rf_wen && (rd != 4'd0)) begin
      rf[rd] <= rf_wdat;
    end
  end

`ifndef SYNTHESIS
  // Prints the architectural state: pc then r0..r15.
  task automatic dump();
    $display("pc  = %016h", pc);
    for (int i = 0; i < 16; i++) begin
      $display("r%0d = %08h", i, (i == 0) ? 32'd0 : rf[i]);
    end
  endtask
`endif

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        ram_clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ram_txe;
  logic        ram_txs = 1'b0;
  logic        ram_re;
  logic [31:0] ram_out = 32'd0;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [63:0] ram_addr;
  logic        hlt;

  int total = 0;
  int bad = 0;
  int ram_half = 5;
  int viol = 0;

  cpu_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ram_txe  (ram_txe),
    .ram_txs  (ram_txs),
    .ram_re   (ram_re),
    .ram_out  (ram_out),
    .ram_we   (ram_we),
    .ram_wd   (ram_wd),
    .ram_addr (ram_addr),
    .hlt      (hlt)
  );

  always #5 clk = ~clk;

  initial begin
    #3;
    forever #(ram_half) ram_clk = ~ram_clk;
  end

  // RAM model: 4-phase slave on its own clock
  logic [31:0] mem [256];
  logic [63:0] rd_log [$];
  logic [63:0] wr_a [$];
  logic [31:0] wr_d [$];

  always @(posedge ram_clk) begin
    if (ram_txe && !ram_txs) begin
      if (ram_re) begin
        ram_out <= mem[ram_addr[9:2]];
        rd_log.push_back(ram_addr);
      end
      if (ram_we) begin
        mem[ram_addr[9:2]] = ram_wd;
        wr_a.push_back(ram_addr);
        wr_d.push_back(ram_wd);
      end
      ram_txs <= 1'b1;
    end else if (!ram_txe && ram_txs) begin
      ram_txs <= 1'b0;
    end
  end

  // bus protocol monitor
  logic        p_txe = 1'b0;
  logic        p_txs = 1'b0;
  logic        p_re = 1'b0;
  logic        p_we = 1'b0;
  logic [63:0] p_addr = 64'd0;
  logic [31:0] p_wd = 32'd0;

  always @(negedge clk) begin
    if (ram_re && ram_we) viol++;
    if (ram_txe && (ram_addr[1:0] != 2'b00)) viol++;
    if (ram_txe && !p_txe && p_txs) viol++;
    if (ram_txe && p_txe &&
        (ram_addr != p_addr || ram_wd != p_wd || ram_re != p_re || ram_we != p_we)) viol++;
    p_txe  = ram_txe;
    p_txs  = ram_txs;
    p_re   = ram_re;
    p_we   = ram_we;
    p_addr = ram_addr;
    p_wd   = ram_wd;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  // pulse reset, check reset values, release
  task automatic start(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_hlt"},  hlt, 0);
    chk({tag, "_rst_txe"},  ram_txe, 0);
    chk({tag, "_rst_rewe"}, {ram_re, ram_we}, 0);
    chk({tag, "_rst_addr"}, ram_addr, 0);
    chk({tag, "_rst_wd"},   ram_wd, 0);
    chk({tag, "_rst_pc"},   dut.pc, 0);
    chk({tag, "_rst_r3"},   dut.rf[3], 0);
    rd_log.delete();
    wr_a.delete();
    wr_d.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_hlt(input string tag, input int budget);
    int n;
    n = 0;
    while (!hlt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_hlt"}, hlt, 1);
  endtask

  task automatic prog1(input string tag);
    clr_mem();
    mem[0] = 32'h1100_0005;  // LI r1,5
    mem[1] = 32'h1200_0007;  // LI r2,7
    mem[2] = 32'h2312_0000;  // ADD r3,r1,r2
    mem[3] = 32'h0000_0000;  // HLT
    start(tag);
    wait_hlt(tag, 4000);
    chk({tag, "_r3"}, dut.rf[3], 12);
    chk({tag, "_pc"}, dut.pc, 12);
    chk({tag, "_nrd"}, rd_log.size(), 4);
    if (rd_log.size() == 4)
      for (int i = 0; i < 4; i++) chk({tag, "_rdaddr"}, rd_log[i], 64'(4 * i));
    chk({tag, "_nwr"}, wr_a.size(), 0);
    repeat (20) @(negedge clk);
    chk({tag, "_hold_hlt"}, hlt, 1);
    chk({tag, "_hold_txe"}, {ram_txe, ram_re, ram_we}, 0);
    chk({tag, "_hold_pc"}, dut.pc, 12);
  endtask

  task automatic prog2(input string tag);
    clr_mem();
    mem[0] = 32'h1100_0040;  // LI r1,0x40
    mem[1] = 32'h12FF_FFFD;  // LI r2,-3
    mem[2] = 32'h9210_0000;  // SW r2,0(r1)
    mem[3] = 32'h8410_0000;  // LW r4,0(r1)
    mem[4] = 32'h0000_0000;  // HLT
    start(tag);
    wait_hlt(tag, 6000);
    chk({tag, "_nwr"}, wr_a.size(), 1);
    if (wr_a.size() == 1) begin
      chk({tag, "_wraddr"}, wr_a[0], 64'h40);
      chk({tag, "_wrdat"}, wr_d[0], 32'hFFFF_FFFD);
    end
    chk({tag, "_r4"}, dut.rf[4], 32'hFFFF_FFFD);
    chk({tag, "_pc"}, dut.pc, 16);
    chk({tag, "_nrd"}, rd_log.size(), 6);
  endtask

  initial begin
    int n;
    int cnt;
    logic saw_low;

    clr_mem();
    #2 rst_n = 1'b0;
    #2;
    chk("init_hlt", hlt, 0);
    chk("init_txe", ram_txe, 0);

    // straight-line ALU program, equal-ish clocks
    prog1("p1");
    dut.dump();

    // store then load
    prog2("p2");

    // countdown loop
    clr_mem();
    mem[0] = 32'h1100_0003;  // LI r1,3
    mem[1] = 32'h7110_FFFF;  // ADDI r1,r1,-1
    mem[2] = 32'hB100_FFFE;  // BNE r1,r0,-2
    mem[3] = 32'h0000_0000;  // HLT
    start("loop");
    wait_hlt("loop", 4000);
    chk("loop_r1", dut.rf[1], 0);
    chk("loop_pc", dut.pc, 12);
    cnt = 0;
    foreach (rd_log[i]) if (rd_log[i] == 64'h4) cnt++;
    chk("loop_addi_fetches", cnt, 3);
    chk("loop_nrd", rd_log.size(), 8);

    // remaining ALU ops, JAL, taken BEQ, wrapped effective address
    clr_mem();
    mem[0]  = 32'h11FF_FFF8;  // LI r1,-8
    mem[1]  = 32'h1200_0003;  // LI r2,3
    mem[2]  = 32'h3312_0000;  // SUB r3,r1,r2
    mem[3]  = 32'h4412_0000;  // AND r4,r1,r2
    mem[4]  = 32'h5512_0000;  // OR  r5,r1,r2
    mem[5]  = 32'h6612_0000;  // XOR r6,r1,r2
    mem[6]  = 32'hD712_0000;  // SLT r7,r1,r2
    mem[7]  = 32'hD821_0000;  // SLT r8,r2,r1
    mem[8]  = 32'hC900_000C;  // JAL r9,r0,12 -> 48
    mem[12] = 32'hA800_0001;  // BEQ r8,r0,+1 -> 56
    mem[14] = 32'h1AFF_FFFC;  // LI r10,-4
    mem[15] = 32'h93A0_0048;  // SW r3,0x48(r10) -> 0x44
    mem[16] = 32'h8BA0_0048;  // LW r11,0x48(r10)
    start("alu");
    wait_hlt("alu", 6000);
    chk("alu_sub", dut.rf[3], 32'hFFFF_FFF5);
    chk("alu_and", dut.rf[4], 32'h0);
    chk("alu_or",  dut.rf[5], 32'hFFFF_FFFB);
    chk("alu_xor", dut.rf[6], 32'hFFFF_FFFB);
    chk("alu_slt1", dut.rf[7], 1);
    chk("alu_slt0", dut.rf[8], 0);
    chk("alu_jal_link", dut.rf[9], 36);
    chk("alu_pc", dut.pc, 68);
    chk("alu_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) chk("alu_wrap_addr", wr_a[0], 64'h44);
    chk("alu_wrap_mem", mem[17], 32'hFFFF_FFF5);
    chk("alu_lw", dut.rf[11], 32'hFFFF_FFF5);

    // branch to itself: never halts, always refetches address 0
    clr_mem();
    mem[0] = 32'hA000_FFFF;  // BEQ r0,r0,-1
    start("self");
    repeat (300) @(negedge clk);
    chk("self_nohlt", hlt, 0);
    chk("self_pc", dut.pc, 0);
    chk("self_many", rd_log.size() >= 3, 1);
    cnt = 0;
    foreach (rd_log[i]) if (rd_log[i] != 64'h0) cnt++;
    chk("self_addr0", cnt, 0);

    // undefined opcode as first instruction
    clr_mem();
    mem[0] = 32'hF123_4567;
    start("undef");
    wait_hlt("undef", 2000);
    chk("undef_pc", dut.pc, 0);
    cnt = 0;
    for (int i = 1; i < 16; i++) if (dut.rf[i] != 32'd0) cnt++;
    chk("undef_regs", cnt, 0);
    chk("undef_nrd", rd_log.size(), 1);

    // r0 ignores writes
    clr_mem();
    mem[0] = 32'h1000_0009;  // LI r0,9
    mem[1] = 32'h2100_0000;  // ADD r1,r0,r0
    start("r0");
    wait_hlt("r0", 2000);
    chk("r0_r1", dut.rf[1], 0);
    chk("r0_pc", dut.pc, 8);

    // RAM clock 10x slower
    ram_half = 50;
    prog1("slow_p1");
    prog2("slow_p2");

    // reset while a fetch is acknowledged
    clr_mem();
    mem[0] = 32'h1100_0005;
    mem[1] = 32'h1200_0007;
    mem[2] = 32'h2312_0000;
    start("mid");
    n = 0;
    while (!(ram_txe && ram_txs) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_inflight", ram_txe && ram_txs, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_txe_drop", ram_txe, 0);
    @(negedge clk);
    rd_log.delete();
    rst_n = 1'b1;
    chk("mid_txs_held", ram_txs, 1);
    saw_low = 1'b0;
    n = 0;
    while (!ram_txe && n < 1000) begin
      if (!ram_txs) saw_low = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("mid_waited_txs", saw_low, 1);
    chk("mid_first_addr", ram_addr, 0);
    wait_hlt("mid", 6000);
    chk("mid_r3", dut.rf[3], 12);
    chk("mid_nrd", rd_log.size(), 4);

    chk("proto_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Small 32-bit load/store CPU that executes a fixed ISA out of an external word RAM.
- It talks to the RAM through a 4-phase request/acknowledge bus (txe/txs), so the RAM may run on a different, slower clock.
- When it executes HLT or an undefined opcode, it asserts hlt and stops. A simulation-only dump task then prints the architectural state.

Parameters:
- RESET_PC, 64'h0, byte address of the first instruction fetched after reset.

Ports:
- clk  input  1  CPU clock. Everything is on the rising edge.
- rst_n  input  1  Reset, asynchronous and active-low.
- ram_txe  output  1  Transaction enable (request) to the RAM.
- ram_txs  input  1  Transaction strobe (acknowledge) from the RAM. Asynchronous to clk.
- ram_re  output  1  Read request qualifier.
- ram_out  input  32  Read data from the RAM. Valid while ram_txs=1 on a read.
- ram_we  output  1  Write request qualifier.
- ram_wd  output  32  Write data.
- ram_addr  output  64  Byte address, word-aligned (bits [1:0]=0).
- hlt  output  1  Halted flag. Held in a register named hlt at the top scope of the module.

Behaviour:
- Architectural state:
  - pc is 64 bits.
  - r0..r15 are 32 bits each. r0 always reads 0 and writes to it are discarded.
- Instruction format:
  - op = [31:28], rd = [27:24], rs = [23:20], rt = [19:16].
  - imm16 = [15:0], sign-extended. imm20 = [19:0], sign-extended.
- Opcodes:
  - 0 HLT.
  - 1 LI: rd = imm20.
  - 2 ADD: rd = rs + rt. 3 SUB: rd = rs - rt. 4 AND, 5 OR, 6 XOR: bitwise, same operand form.
  - 7 ADDI: rd = rs + imm16.
  - 8 LW: rd = M[rs + imm16].
  - 9 SW: M[rs + imm16] = rd.
  - A BEQ: if rd == rs, pc = pc + 4 + imm16*4. B BNE: same target when rd != rs.
  - C JAL: rd = pc[31:0] + 4; pc = zext(rs + imm16*4).
  - D SLT: rd = signed(rs) < signed(rt).
  - E and F are undefined and halt the CPU exactly like HLT.
- Arithmetic is 32-bit and wraps modulo 2^32.
- Memory address = zero-extend(rs + imm16) to 64 bits, with bits [1:0] forced to 0. Branch targets use 64-bit arithmetic.
- Non-control instructions advance pc by 4.
- Bus handshake (4-phase, CPU side):
  - ram_txs is passed through a 2-flop synchronizer before use.
  - A request is issued only when synchronized txs=0. Issuing means driving addr, and re or we (never both), and wd for writes, then raising txe in the same cycle.
  - addr, re, we and wd are held stable while txe=1.
  - On synchronized txs=1: for a read, ram_out is latched; then txe, re and we drop.
  - The next request waits until synchronized txs returns to 0.
- State machine:
  - IF_REQ → IF_ACK (latch instruction) → IF_REL (wait for txs=0) → EX.
  - EX handles everything except LW/SW in one cycle, then goes to IF_REQ.
  - LW/SW go EX → MEM_REQ → MEM_ACK → MEM_REL → IF_REQ. LW writes rd at MEM_ACK.
  - HLT or undefined opcode: EX → HALT. HALT is terminal until reset.
- Halt:
  - hlt rises in the cycle the CPU enters HALT and stays 1.
  - In HALT, txe, re and we stay 0 and pc does not advance (it holds the halting instruction's address).
- Reset values (asserted asynchronously):
  - pc = RESET_PC, all registers 0, hlt = 0.
  - ram_txe, re, we = 0; wd = 0; addr = 0; synchronizer flops 0; state = IF_REL.
  - Starting in IF_REL means that after a reset in the middle of a transaction, the CPU waits for the RAM to drop txs before its first fetch.
- Throughput: no pipelining, at most one outstanding transaction.
- Boundary cases:
  - A branch with imm16 = -1 targets itself.
  - A 32-bit address wrap in LW/SW stays within the low 4 GiB.
- dump task (simulation-only): prints pc and r0..r15 in hex, one per line.

Test Plan:
- Reset then release, RAM = {LI r1,5; LI r2,7; ADD r3,r1,r2; HLT} → hlt=1; r3=12; pc=12; exactly 4 read transactions at addresses 0, 4, 8, 12.
- Store and load: LI r1,0x40; LI r2,-3; SW r2,0(r1); LW r4,0(r1); HLT → one write with addr 0x40 and wd 0xFFFFFFFD; r4=0xFFFFFFFD.
- Loop: LI r1,3; ADDI r1,r1,-1; BNE r1,r0,-2; HLT → r1=0; the ADDI word is fetched 3 times; hlt=1.
- Handshake checks:
  - Requests are never issued while txs=1; re and we are never both 1.
  - addr and wd stay stable while txe=1.
  - With the RAM clock 10x slower than the CPU clock, results match the equal-clock run.
- rst_n pulsed low while a fetch is in flight with txs=1 → txe drops immediately; the first new fetch of address 0 issues only after txs=0.
- Opcode 0xF as the first instruction → hlt=1; pc=0; r1..r15 remain 0; writes to r0 via LI r0,9 leave r0=0.
